field_config_rom: RTL and testbench
===================================

Name: field_config_rom

Overview:
- Read-only store of the initial Game-of-Life field, selected at elaboration time by CONFIG_ID.
- The field loader and display scan cells by (x, y) address; the block returns that cell's alive/dead state one clock later.
- Contents are computed per address from the selected pattern formula; no memory-init files.
- Sits between the configuration selection and the field-state RAM initialisation logic.

Parameters:
- FIELD_W, 3: field width in cells; must be >= 2.
- FIELD_H, 3: field height in cells; must be >= 2.
- CONFIG_ID, 1000: integer pattern selector; legal values are listed under Behaviour.
- X_ADR_SIZE, $clog2(FIELD_W): derived; x address width.
- Y_ADR_SIZE, $clog2(FIELD_H): derived; y address width.

Ports:
- i_clk  input  1  system clock, rising edge active.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_cell_x_adr  input  X_ADR_SIZE  cell column; 0 is the leftmost column.
- i_cell_y_adr  input  Y_ADR_SIZE  cell row; 0 is the top row.
- o_cell_state  output  1  1 = alive, 0 = dead, for the address presented in the previous cycle.

Behaviour:
- Reset:
  - While i_rst_n = 0, o_cell_state = 0, asynchronously.
  - After release, the first valid data appears at the first rising edge.
- Latency:
  - Registered read, 1 cycle.
  - The address sampled at rising edge N gives the data at o_cell_state after edge N.
  - The output holds between edges.
  - A new address can be presented every cycle (full throughput); there is no handshake.
- Out-of-range addresses:
  - If x >= FIELD_W or y >= FIELD_H (possible when a dimension is not a power of two), the output is 0.
- Patterns, selected by CONFIG_ID:
  - 0 EMPTY: all cells dead.
  - 1 FULL: all cells alive.
  - 2 GLIDER: alive at (1,0), (2,1), (0,2), (1,2), (2,2); every other cell is dead. Cells falling outside the field are clipped.
  - 3 BLINKER: alive when y == FIELD_H/2 and x is in {FIELD_W/2-1, FIELD_W/2, FIELD_W/2+1}. Integer division; clip at the edges.
  - 4 R_PENTOMINO: with cx = FIELD_W/2 and cy = FIELD_H/2, alive at (cx,cy-1), (cx+1,cy-1), (cx-1,cy), (cx,cy), (cx,cy+1). Clip at the edges.
  - 1000 CHECKER (test pattern): alive when (x + y) is even.
  - Any other value: all cells dead.
- The address-to-state computation is purely combinational in front of the single output flop. There is no other state.
- Address inputs are sampled only at clock edges, so glitches between edges have no effect.
- Reset asserted mid-scan:
  - The output clears immediately.
  - After release, the block resumes with the address present at the next edge.
  - No other state is lost.

Decomposition:
- Package field_rom_pkg holds:
  - integer constants CFG_EMPTY=0, CFG_FULL=1, CFG_GLIDER=2, CFG_BLINKER=3, CFG_RPENT=4, CFG_CHECKER=1000;
  - a function is_alive(x, y, w, h, cfg) returning a bit, so the field RAM initialiser reuses it.
- One sub-module, field_pattern_lut: combinational, parameterised like the top, mapping (x, y) to the alive bit for CONFIG_ID.
- The top adds the range check and the output register.

Test Plan:
- Reset: hold i_rst_n = 0 with the address at (0,0) and CONFIG_ID=1000 -> o_cell_state = 0. Release, then one edge later -> o_cell_state = 1.
- CONFIG_ID=1000, 3x3: scan rows y = 0..2, each with x = 0..2, one address per cycle; sample 1 cycle after each -> rows read "101", "010", "101".
- CONFIG_ID=1000, 3x3: present x=3, y=0, then x=0, y=3 -> output 0 both times.
- CONFIG_ID=2, 4x4 scan -> rows "0100", "0010", "1110", "0000".
- CONFIG_ID=3 on 5x5 -> only row 2 = "01110"; every other row is "00000". CONFIG_ID=7 on 5x5 -> all zeros.
- Back-to-back addresses (0,0), (1,0), (0,0) on consecutive edges with CONFIG_ID=1000 -> outputs 1, 0, 1, each on the following cycle. Assert i_rst_n low mid-scan -> output 0 immediately, asynchronously.

Source files
------------

// File: rtl/field_config_rom_pkg.sv
// Shared pattern constants and the per-cell pattern formula.
// The field RAM initialiser calls the same function.
package field_rom_pkg;

  localparam int CFG_EMPTY   = 0;
  localparam int CFG_FULL    = 1;
  localparam int CFG_GLIDER  = 2;
  localparam int CFG_BLINKER = 3;
  localparam int CFG_RPENT   = 4;
  localparam int CFG_CHECKER = 1000;

  function automatic bit is_alive(
    input int x,
    input int y,
    input int w,
    input int h,
    input int cfg
  );
    bit a;
    int cx;
    int cy;
    a  = 1'b0;
    cx = w / 2;
    cy = h / 2;
    // Cells outside the field are clipped here as well.
    if (x < w && y < h) begin
      case (cfg)
        CFG_FULL:    a = 1'b1;
        CFG_GLIDER:  a = (x == 1 && y == 0)
                      || (x == 2 && y == 1)
                      || (y == 2 && x <= 2);
        CFG_BLINKER: a = (y == cy)
                      && (x >= cx - 1)
                      && (x <= cx + 1);
        CFG_RPENT:   a = (y == cy - 1 && (x == cx || x == cx + 1))
                      || (y == cy && (x == cx - 1 || x == cx))
                      || (y == cy + 1 && x == cx);
        CFG_CHECKER: a = ((x + y) % 2) == 0;
        default:     a = 1'b0;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/field_config_rom_if.sv
// Cell address / state bundle between a field scanner and the ROM.
// No handshake: one address per cycle, data one cycle later.
interface field_config_rom_if #(
  parameter int X_ADR_SIZE = 2,
  parameter int Y_ADR_SIZE = 2
);

  logic [X_ADR_SIZE-1:0] cell_x_adr;
  logic [Y_ADR_SIZE-1:0] cell_y_adr;
  logic                  cell_state;

  modport master (
    output cell_x_adr,
    output cell_y_adr,
    input  cell_state
  );

  modport slave (
    input  cell_x_adr,
    input  cell_y_adr,
    output cell_state
  );

endinterface

// File: rtl/field_pattern_lut.sv
// Combinational (x, y) -> alive map for the elaborated pattern.
// Pure logic; the top owns range check and output flop.
module field_pattern_lut
  import field_rom_pkg::*;
#(
  parameter int FIELD_W    = 3,
  parameter int FIELD_H    = 3,
  parameter int CONFIG_ID  = 1000,
  parameter int X_ADR_SIZE = $clog2(FIELD_W),
  parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic [X_ADR_SIZE-1:0] x_i,
  input  logic [Y_ADR_SIZE-1:0] y_i,
  output logic                  alive_o
);

  always_comb begin
    alive_o = is_alive(
      int'(x_i),
      int'(y_i),
      FIELD_W,
      FIELD_H,
      CONFIG_ID
    );
  end

endmodule

// File: rtl/field_config_rom.sv
// Initial Game-of-Life field ROM: pattern formula, range check,
// and a single registered output.
module field_config_rom
  import field_rom_pkg::*;
#(
  parameter int FIELD_W    = 3,
  parameter int FIELD_H    = 3,
  parameter int CONFIG_ID  = 1000,
  parameter int X_ADR_SIZE = $clog2(FIELD_W),
  parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [X_ADR_SIZE-1:0] i_cell_x_adr,
  input  logic [Y_ADR_SIZE-1:0] i_cell_y_adr,
  output logic                  o_cell_state
);

  logic alive;
  logic in_range;
  logic cell_d;
  logic cell_q;

  field_pattern_lut #(
    .FIELD_W    (FIELD_W),
    .FIELD_H    (FIELD_H),
    .CONFIG_ID  (CONFIG_ID),
    .X_ADR_SIZE (X_ADR_SIZE),
    .Y_ADR_SIZE (Y_ADR_SIZE)
  ) u_lut (
    .x_i     (i_cell_x_adr),
    .y_i     (i_cell_y_adr),
    .alive_o (alive)
  );

  // Non power-of-two fields leave unused address codes.
  always_comb begin
    in_range = (int'(i_cell_x_adr) < FIELD_W)
            && (int'(i_cell_y_adr) < FIELD_H);
    cell_d   = in_range & alive;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cell_q <= 1'b0;
    end else begin
      cell_q <= cell_d;
    end
  end

  assign o_cell_state = cell_q;

endmodule

// File: tb/tb_field_config_rom.sv
// Scoreboard bench for field_config_rom over four configurations.
// Directed addresses with hand-computed expected cell states.
module tb_field_config_rom;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  field_config_rom_if #(.X_ADR_SIZE(2), .Y_ADR_SIZE(2)) ifa ();
  field_config_rom_if #(.X_ADR_SIZE(2), .Y_ADR_SIZE(2)) ifb ();
  field_config_rom_if #(.X_ADR_SIZE(3), .Y_ADR_SIZE(3)) ifc ();
  field_config_rom_if #(.X_ADR_SIZE(3), .Y_ADR_SIZE(3)) ifd ();

  field_config_rom #(
    .FIELD_W(3), .FIELD_H(3), .CONFIG_ID(1000)
  ) dut_a (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cell_x_adr (ifa.cell_x_adr),
    .i_cell_y_adr (ifa.cell_y_adr),
    .o_cell_state (ifa.cell_state)
  );

  field_config_rom #(
    .FIELD_W(4), .FIELD_H(4), .CONFIG_ID(2)
  ) dut_b (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cell_x_adr (ifb.cell_x_adr),
    .i_cell_y_adr (ifb.cell_y_adr),
    .o_cell_state (ifb.cell_state)
  );

  field_config_rom #(
    .FIELD_W(5), .FIELD_H(5), .CONFIG_ID(3)
  ) dut_c (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cell_x_adr (ifc.cell_x_adr),
    .i_cell_y_adr (ifc.cell_y_adr),
    .o_cell_state (ifc.cell_state)
  );

  field_config_rom #(
    .FIELD_W(5), .FIELD_H(5), .CONFIG_ID(7)
  ) dut_d (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cell_x_adr (ifd.cell_x_adr),
    .i_cell_y_adr (ifd.cell_y_adr),
    .o_cell_state (ifd.cell_state)
  );

  typedef struct {
    int    id;
    bit    e;
    string nm;
  } ent_t;

  ent_t q[$];
  int   checks;
  int   failures;
  logic issue;
  logic vld;

  function automatic logic out_of(input int id);
    case (id)
      0:       return ifa.cell_state;
      1:       return ifb.cell_state;
      2:       return ifc.cell_state;
      default: return ifd.cell_state;
    endcase
  endfunction

  task automatic check(input string nm, input logic act, input logic e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, act, e);
    end
  endtask

  // Issue one address at a negedge; result is due one negedge later.
  task automatic put(input int id, input int x, input int y,
                     input bit e, input string tag);
    ent_t en;
    @(negedge clk);
    case (id)
      0: begin
        ifa.cell_x_adr = x[1:0];
        ifa.cell_y_adr = y[1:0];
      end
      1: begin
        ifb.cell_x_adr = x[1:0];
        ifb.cell_y_adr = y[1:0];
      end
      2: begin
        ifc.cell_x_adr = x[2:0];
        ifc.cell_y_adr = y[2:0];
      end
      default: begin
        ifd.cell_x_adr = x[2:0];
        ifd.cell_y_adr = y[2:0];
      end
    endcase
    en.id = id;
    en.e  = e;
    en.nm = $sformatf("%s(%0d,%0d)", tag, x, y);
    q.push_back(en);
    issue = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    issue = 1'b0;
  endtask

  always @(posedge clk) vld <= issue;

  // Monitor: pop and compare whenever an issued read has landed.
  always @(negedge clk) begin
    if (vld === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow got=empty exp=entry");
      end else begin
        ent_t en;
        en = q.pop_front();
        check(en.nm, out_of(en.id), en.e);
      end
    end
  end

  string rows_a[3] = '{"101", "010", "101"};
  string rows_b[4] = '{"0100", "0010", "1110", "0000"};
  string rows_c[5] = '{"00000", "00000", "01110", "00000", "00000"};

  initial begin
    checks   = 0;
    failures = 0;
    issue    = 1'b0;
    vld      = 1'b0;
    rst_n    = 1'b0;
    ifa.cell_x_adr = '0;
    ifa.cell_y_adr = '0;
    ifb.cell_x_adr = '0;
    ifb.cell_y_adr = '0;
    ifc.cell_x_adr = '0;
    ifc.cell_y_adr = '0;
    ifd.cell_x_adr = '0;
    ifd.cell_y_adr = '0;

    #3;
    check("reset_a", ifa.cell_state, 1'b0);
    @(posedge clk);
    #1;
    check("reset_a_edge", ifa.cell_state, 1'b0);
    check("reset_b_edge", ifb.cell_state, 1'b0);
    #1;
    rst_n = 1'b1;

    put(0, 0, 0, 1'b1, "release_chk");

    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        put(0, x, y, rows_a[y][x] == "1", "chk");

    put(0, 3, 0, 1'b0, "chk_oor");
    put(0, 0, 3, 1'b0, "chk_oor");
    put(0, 3, 1, 1'b0, "chk_oor");
    put(0, 3, 3, 1'b0, "chk_oor");

    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        put(1, x, y, rows_b[y][x] == "1", "glider");

    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        put(2, x, y, rows_c[y][x] == "1", "blinker");

    put(2, 5, 2, 1'b0, "blinker_oor");

    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        put(3, x, y, 1'b0, "cfg7");

    put(0, 0, 0, 1'b1, "b2b");
    put(0, 1, 0, 1'b0, "b2b");
    put(0, 0, 0, 1'b1, "b2b");
    idle();

    #2;
    check("pre_reset_hold", ifa.cell_state, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_clear", ifa.cell_state, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", ifa.cell_state, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    put(0, 2, 2, 1'b1, "resume");
    put(0, 2, 1, 1'b0, "resume");
    idle();
    idle();
    idle();

    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
